// File: rtl/work_loader.sv
// Work loader: assembles a mining work frame (sync byte, header and target payload, and
// optionally a trailing XOR checksum) from a byte stream into a shadow buffer. On a good frame
// it commits header/target to the miner atomically and pulses miner_reset_o.
// Optional feature macro: WORK_LOADER_CHECKSUM_EN (adds the checksum byte and CHECK state).
module work_loader #(
  parameter int unsigned HEADER_BYTES   = 76,
  parameter int unsigned TARGET_BYTES   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned RST_CYCLES     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  output logic [8*HEADER_BYTES-1:0] header_o,
  output logic [8*TARGET_BYTES-1:0] target_o,
  output logic                      work_valid_o,
  output logic                      miner_reset_o,
  output logic                      frame_err_o
);

  localparam int unsigned PayloadBytes = HEADER_BYTES + TARGET_BYTES;
  localparam int unsigned TmoW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RstW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [7:0]      SyncByte = 8'hA5;
  localparam logic [6:0]      LastIdx  = 7'(PayloadBytes - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax   = TmoW'(TIMEOUT_CYCLES);
  localparam logic [RstW-1:0] RstLast  = RstW'(RST_CYCLES - 1);

`ifdef WORK_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StRestart} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StRestart} state_e;
`endif

  state_e                    state_q;
  logic [6:0]                idx_q;
  logic [TmoW-1:0]           tmo_q;
  logic [RstW-1:0]           rst_cnt_q;
  logic [8*PayloadBytes-1:0] shadow_q;
  logic [8*PayloadBytes-1:0] shadow_d;
  logic                      rx_ready_q;
  logic [8*HEADER_BYTES-1:0] header_q;
  logic [8*TARGET_BYTES-1:0] target_q;
  logic                      work_valid_q;
  logic                      miner_reset_q;
  logic                      frame_err_q;
  logic                      accept;
`ifdef WORK_LOADER_CHECKSUM_EN
  logic [7:0]                xor_q;
  logic [7:0]                xor_d;
`endif

  assign accept = rx_valid_i & rx_ready_q;

  // Shadow buffer with the incoming byte dropped into its little-endian slot.
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[8*idx_q +: 8] = rx_data_i;
`ifdef WORK_LOADER_CHECKSUM_EN
    xor_d = xor_q ^ rx_data_i;
`endif
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      tmo_q         <= '0;
      rst_cnt_q     <= '0;
      shadow_q      <= '0;
      rx_ready_q    <= 1'b0;
      header_q      <= '0;
      target_q      <= '0;
      work_valid_q  <= 1'b0;
      miner_reset_q <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef WORK_LOADER_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          rx_ready_q <= 1'b1;
          if (accept && (rx_data_i == SyncByte)) begin
            state_q <= StLoad;
            idx_q   <= '0;
            tmo_q   <= '0;
`ifdef WORK_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
          end
        end
        StLoad: begin
          if (accept) begin
            // Sync value is ordinary payload here; no resync inside a frame.
            shadow_q <= shadow_d;
            tmo_q    <= '0;
            idx_q    <= idx_q + 7'd1;
`ifdef WORK_LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
            if (idx_q == LastIdx) begin
              state_q <= StCheck;
            end
`else
            if (idx_q == LastIdx) begin
              {target_q, header_q} <= shadow_d;
              work_valid_q         <= 1'b1;
              miner_reset_q        <= 1'b1;
              rx_ready_q           <= 1'b0;
              rst_cnt_q            <= '0;
              state_q              <= StRestart;
            end
`endif
          end else if (tmo_q == TmoLast) begin
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
          end else if (tmo_q != TmoMax) begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
`ifdef WORK_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            tmo_q <= '0;
            if (rx_data_i == xor_q) begin
              {target_q, header_q} <= shadow_q;
              work_valid_q         <= 1'b1;
              miner_reset_q        <= 1'b1;
              rx_ready_q           <= 1'b0;
              rst_cnt_q            <= '0;
              state_q              <= StRestart;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StIdle;
            end
          end else if (tmo_q == TmoLast) begin
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
          end else if (tmo_q != TmoMax) begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
`endif
        StRestart: begin
          // Hold the miner in reset and refuse bytes for RST_CYCLES cycles.
          if (rst_cnt_q == RstLast) begin
            miner_reset_q <= 1'b0;
            rx_ready_q    <= 1'b1;
            state_q       <= StIdle;
          end else begin
            rst_cnt_q <= rst_cnt_q + RstW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rx_ready_o    = rx_ready_q;
  assign header_o      = header_q;
  assign target_o      = target_q;
  assign work_valid_o  = work_valid_q;
  assign miner_reset_o = miner_reset_q;
  assign frame_err_o   = frame_err_q;

endmodule
